vec_dot_engine: RTL and testbench
=================================

# vec_dot_engine

Parametrised multi-lane signed dot-product engine for the matrix/vector datapath. It computes the dot product of two packed vectors, processing LANES element pairs per cycle over a runtime-selectable length. It uses a start/busy request handshake and an out_valid/out_ready result handshake, with optional shift-and-saturate output scaling. It is the next generation of the single-PE serial vector-vector unit and drops into the same V1/V2 packed-bus slot.

## Interface
- DIMENSION, 16, maximum vector length in elements; must be a multiple of LANES.
- WIDTH, 8, element width in bits; elements are signed two's complement.
- LANES, 4, multipliers used in parallel per cycle; 1 ≤ LANES ≤ DIMENSION.
- ACC_WIDTH, 20, accumulator width; must be ≥ 2*WIDTH + clog2(DIMENSION).
- OUT_WIDTH, 8, width of the scaled result VV.
- SHIFT, 0, arithmetic right shift applied to acc before narrowing.
- SAT, 1, 1 = saturate on narrowing, 0 = truncate (keep the low OUT_WIDTH bits).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- len  in  clog2(DIMENSION+1)  active element count; sampled when start is accepted.
- V1, V2  in  DIMENSION*WIDTH  packed signed vectors, element i at [(i+1)*WIDTH-1 : i*WIDTH]; sampled when start is accepted.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in RUN and DONE.
- out_valid  out  1  result valid; high only in DONE.
- acc_o  out  ACC_WIDTH  full-precision signed sum.
- VV  out  OUT_WIDTH  scaled and narrowed result.
- ovf  out  1  narrowing changed the value (saturated, or truncation lost significant bits).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch V1, V2 and the effective length n_eff. n_eff = len, except len=0 or len>DIMENSION gives n_eff=DIMENSION.
  - Clear acc. Set idx=0. Go to RUN.
- IDLE, start=0: hold.
- RUN, each cycle:
  - Compute products v1[idx+k]*v2[idx+k] for k = 0..LANES-1, each 2*WIDTH signed.
  - Force a lane's product to zero when idx+k ≥ n_eff.
  - Sign-extend the lane products, sum them, and add the sum to acc.
  - Advance idx by LANES.
  - When idx+LANES ≥ n_eff, this is the last RUN cycle; go to DONE on the same edge.
- DONE:
  - out_valid=1. acc_o, VV and ovf are registered and stable.
  - If out_ready=1, go to IDLE on that edge; out_valid drops the following cycle.
- start is ignored in RUN and DONE; there is no queuing.
- Scaling: s = acc >>> SHIFT (arithmetic shift).
  - SAT=1: VV = clamp(s, −2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1); ovf=1 when clamping occurred.
  - SAT=0: VV = s[OUT_WIDTH−1:0]; ovf=1 when s does not fit in OUT_WIDTH bits.
- VV and ovf are registered on entry to DONE.
- acc cannot overflow, given the ACC_WIDTH constraint.

## Timing
- rst=0 on an edge returns the block to IDLE from any state, including mid-RUN or DONE. The in-flight result is lost.
- Reset values: busy=0, out_valid=0, acc_o=0, VV=0, ovf=0; internal idx=0.
- rst has priority over start and out_ready.
- Start accepted at edge T0: busy=1 from T0.
- RUN lasts ceil(n_eff/LANES) cycles. out_valid rises after edge T0+ceil(n_eff/LANES).
  - Defaults with len=16: out_valid after T0+4.
- Handshake completes on the edge where out_valid=1 and out_ready=1; busy=0 after that edge.
- Earliest next start: the cycle after the handshake edge. A start already high on the handshake edge is not accepted on that edge.
- Outputs hold their last values in IDLE until the next acceptance. acc_o clears at acceptance.

## Test plan
- All V1=1, V2=2, len=16, out_ready=1 → out_valid exactly 4 cycles after the start edge; acc_o=32, VV=32, ovf=0; busy=0 the cycle after out_valid.
- Element i of V1 and V2 = i, len=5 → 2 RUN cycles; acc_o=30 (0+1+4+9+16), VV=30. Lanes 5..7 are masked even though V1/V2 beyond element 4 hold nonzero data.
- V1=V2 all 127, len=0 (treated as 16) → acc_o=258064, VV=127, ovf=1. Then V1 all −128, V2 all 127 → acc_o=−260096, VV=−128, ovf=1. Repeat with SAT=0, SHIFT=12: VV=63, ovf=0.
- Backpressure: out_ready=0 for 3 cycles in DONE while start pulses → VV and acc_o stable, no new acceptance. Raise out_ready → IDLE after that edge; a start one cycle later is accepted.
- rst=0 asserted during the 2nd RUN cycle → after that edge all outputs are 0 and the state is IDLE. A new start with ones×ones and len=8 then yields acc_o=8 after 2 RUN cycles.
- Back-to-back: hold out_ready=1 and issue start the cycle after each handshake, 3 jobs with len 1, 4 and 16 → latencies of 1, 1 and 4 cycles, with correct sums per job.

Source files
------------

// File: rtl/vec_dot_engine.sv
// vec_dot_engine: multi-lane signed dot-product engine.
// Consumes LANES element pairs per cycle from latched packed vectors,
// accumulates at full precision, then scales and narrows the result.
// Request handshake: start/busy. Result handshake: out_valid/out_ready.
module vec_dot_engine #(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 20,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0,
    parameter int SAT       = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(DIMENSION+1)-1:0] len,
    input  logic [DIMENSION*WIDTH-1:0]     V1,
    input  logic [DIMENSION*WIDTH-1:0]     V2,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           out_valid,
    output logic [ACC_WIDTH-1:0]           acc_o,
    output logic [OUT_WIDTH-1:0]           VV,
    output logic                           ovf
);

    localparam int LEN_W = $clog2(DIMENSION + 1);
    // One extra bit so idx+lane comparisons never wrap.
    localparam int CW    = LEN_W + 1;
    localparam int VW    = DIMENSION * WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Control decoded from the FSM.
    logic accept;

    // Datapath state.
    logic [VW-1:0]                 v1_sh, v2_sh;
    logic [LEN_W-1:0]              idx;
    logic [LEN_W-1:0]              n_eff;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [OUT_WIDTH-1:0]          vv_r;
    logic                          ovf_r;

    // Datapath combinational results.
    logic [LEN_W-1:0]              n_eff_in;
    logic signed [2*WIDTH-1:0]     prod [LANES];
    logic signed [ACC_WIDTH-1:0]   lane_sum;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   scaled;
    logic                          fits;
    logic                          last_cycle;
    logic [OUT_WIDTH-1:0]          vv_next;
    logic                          ovf_next;

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a branch that skips it infers a latch.
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_cycle) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane products, masked sum, accumulation and output scaling.
    always_comb begin
        n_eff_in = len;
        if (len == '0 || len > LEN_W'(DIMENSION)) begin
            n_eff_in = LEN_W'(DIMENSION);
        end

        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            prod[k] = $signed(v1_sh[k*WIDTH +: WIDTH]) * $signed(v2_sh[k*WIDTH +: WIDTH]);
            // Lanes past the active length contribute nothing, whatever data they hold.
            if ((CW'(idx) + CW'(k)) < CW'(n_eff)) begin
                lane_sum = lane_sum + ACC_WIDTH'(prod[k]);
            end
        end
        acc_next   = acc + lane_sum;
        last_cycle = (CW'(idx) + CW'(LANES)) >= CW'(n_eff);

        scaled = acc_next >>> SHIFT;
        fits   = (scaled >= OUT_MIN) && (scaled <= OUT_MAX);
        // Either mode flags any value that does not survive narrowing intact.
        ovf_next = !fits;
        vv_next  = scaled[OUT_WIDTH-1:0];
        if (SAT != 0 && !fits) begin
            vv_next = scaled[ACC_WIDTH-1] ? OUT_MIN[OUT_WIDTH-1:0] : OUT_MAX[OUT_WIDTH-1:0];
        end
    end

    // Index, length, accumulator and registered result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx   <= '0;
            n_eff <= '0;
            acc   <= '0;
            vv_r  <= '0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            n_eff <= n_eff_in;
            acc   <= '0;
        end else if (state == RUN) begin
            idx <= idx + LEN_W'(LANES);
            acc <= acc_next;
            if (last_cycle) begin
                vv_r  <= vv_next;
                ovf_r <= ovf_next;
            end
        end
    end

    // Operand storage: loaded on accept, shifted down one lane group per RUN cycle.
    always_ff @(posedge clk) begin
        // NOTE: the operand vectors are deliberately left out of reset; they are
        // always reloaded on accept before anything reads them.
        if (accept) begin
            v1_sh <= V1;
            v2_sh <= V2;
        end else if (state == RUN) begin
            v1_sh <= v1_sh >> (LANES * WIDTH);
            v2_sh <= v2_sh >> (LANES * WIDTH);
        end
    end

    assign acc_o = acc;
    assign VV    = vv_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_vec_dot_engine.sv
// Directed testbench for vec_dot_engine.
// Main instance uses the default parameters; a second instance with
// SAT=0, SHIFT=12 shares the stimulus to cover truncating scaling.
module tb_vec_dot_engine;

    localparam int DIM   = 16;
    localparam int W     = 8;
    localparam int VW    = DIM * W;
    localparam int LEN_W = $clog2(DIM + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [VW-1:0]    v1, v2;
    logic             out_ready;

    logic             busy, out_valid, ovf;
    logic [19:0]      acc_o;
    logic [7:0]       VV;

    logic             busy_t, out_valid_t, ovf_t;
    logic [19:0]      acc_o_t;
    logic [7:0]       vv_t;

    int checks   = 0;
    int failures = 0;

    vec_dot_engine u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .V1(v1), .V2(v2),
        .out_ready(out_ready), .busy(busy), .out_valid(out_valid),
        .acc_o(acc_o), .VV(VV), .ovf(ovf)
    );

    vec_dot_engine #(.SAT(0), .SHIFT(12)) u_dut_trunc (
        .clk(clk), .rst(rst), .start(start), .len(len), .V1(v1), .V2(v2),
        .out_ready(out_ready), .busy(busy_t), .out_valid(out_valid_t),
        .acc_o(acc_o_t), .VV(vv_t), .ovf(ovf_t)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [VW-1:0] fill(input logic [W-1:0] val);
        logic [VW-1:0] r;
        for (int i = 0; i < DIM; i++) r[i*W +: W] = val;
        return r;
    endfunction

    function automatic logic [VW-1:0] ramp();
        logic [VW-1:0] r;
        for (int i = 0; i < DIM; i++) r[i*W +: W] = W'(i);
        return r;
    endfunction

    // Issue one request from IDLE; returns busy right after the accept edge
    // and the number of edges from accept until out_valid is seen.
    task automatic do_job(input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [LEN_W-1:0] n, output logic busy_acc, output int lat);
        v1 = a; v2 = b; len = n; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        busy_acc = busy;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; out_ready = 1'b0; len = '0; v1 = '0; v2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (acc_o !== 20'd0 || VV !== 8'd0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_outputs got acc=%0d vv=%0d ovf=%b exp 0/0/0", acc_o, VV, ovf); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy got=%b exp=0", busy); end
    endtask

    task automatic test_ones();
        logic b; int lat;
        out_ready = 1'b1;
        do_job(fill(8'd1), fill(8'd2), 5'd16, b, lat);
        checks++; if (b !== 1'b1) begin failures++; $display("FAIL ones_busy_on_accept got=%b exp=1", b); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL ones_latency got=%0d exp=4", lat); end
        checks++; if ($signed(acc_o) !== 32) begin failures++; $display("FAIL ones_acc got=%0d exp=32", $signed(acc_o)); end
        checks++; if ($signed(VV) !== 32 || ovf !== 1'b0) begin failures++; $display("FAIL ones_vv got=%0d/%b exp=32/0", $signed(VV), ovf); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL ones_release got busy=%b valid=%b exp 0/0", busy, out_valid); end
    endtask

    task automatic test_mask();
        logic b; int lat;
        do_job(ramp(), ramp(), 5'd5, b, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL mask_latency got=%0d exp=2", lat); end
        checks++; if ($signed(acc_o) !== 30 || $signed(VV) !== 30) begin failures++; $display("FAIL mask_result got acc=%0d vv=%0d exp 30/30", $signed(acc_o), $signed(VV)); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        logic b; int lat;
        do_job(fill(8'd127), fill(8'd127), 5'd0, b, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL sat_pos_latency got=%0d exp=4", lat); end
        checks++; if ($signed(acc_o) !== 258064) begin failures++; $display("FAIL sat_pos_acc got=%0d exp=258064", $signed(acc_o)); end
        checks++; if ($signed(VV) !== 127 || ovf !== 1'b1) begin failures++; $display("FAIL sat_pos_vv got=%0d/%b exp=127/1", $signed(VV), ovf); end
        checks++; if ($signed(vv_t) !== 63 || ovf_t !== 1'b0) begin failures++; $display("FAIL trunc_pos_vv got=%0d/%b exp=63/0", $signed(vv_t), ovf_t); end
        @(posedge clk); #1;
        do_job(fill(8'h80), fill(8'd127), 5'd16, b, lat);
        checks++; if ($signed(acc_o) !== -260096) begin failures++; $display("FAIL sat_neg_acc got=%0d exp=-260096", $signed(acc_o)); end
        checks++; if ($signed(VV) !== -128 || ovf !== 1'b1) begin failures++; $display("FAIL sat_neg_vv got=%0d/%b exp=-128/1", $signed(VV), ovf); end
        checks++; if ($signed(vv_t) !== -64 || ovf_t !== 1'b0) begin failures++; $display("FAIL trunc_neg_vv got=%0d/%b exp=-64/0", $signed(vv_t), ovf_t); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic b; int lat;
        out_ready = 1'b0;
        do_job(fill(8'd1), fill(8'd3), 5'd4, b, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL bp_latency got=%0d exp=1", lat); end
        // Hold in DONE while start is pushed; nothing may move.
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; v1 = fill(8'd9); len = 5'd16;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || $signed(acc_o) !== 12 || $signed(VV) !== 12) begin failures++; $display("FAIL bp_hold_%0d got valid=%b acc=%0d vv=%0d exp 1/12/12", i, out_valid, $signed(acc_o), $signed(VV)); end
        end
        // start still high on the handshake edge: must not be taken there.
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_handshake got busy=%b valid=%b exp 0/0", busy, out_valid); end
        checks++; if ($signed(acc_o) !== 12) begin failures++; $display("FAIL bp_idle_hold_acc got=%0d exp=12", $signed(acc_o)); end
        do_job(fill(8'd1), fill(8'd3), 5'd8, b, lat);
        checks++; if (b !== 1'b1) begin failures++; $display("FAIL bp_next_accept got=%b exp=1", b); end
        checks++; if (lat !== 2 || $signed(acc_o) !== 24) begin failures++; $display("FAIL bp_next_job got lat=%0d acc=%0d exp 2/24", lat, $signed(acc_o)); end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_run();
        logic b; int lat;
        v1 = fill(8'd1); v2 = fill(8'd5); len = 5'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        // Now in the second RUN cycle.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_run_ctrl got busy=%b valid=%b exp 0/0", busy, out_valid); end
        checks++; if (acc_o !== 20'd0 || VV !== 8'd0 || ovf !== 1'b0) begin failures++; $display("FAIL rst_run_outputs got acc=%0d vv=%0d ovf=%b exp 0/0/0", acc_o, VV, ovf); end
        do_job(fill(8'd1), fill(8'd1), 5'd8, b, lat);
        checks++; if (lat !== 2 || $signed(acc_o) !== 8) begin failures++; $display("FAIL rst_run_restart got lat=%0d acc=%0d exp 2/8", lat, $signed(acc_o)); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic b; int lat;
        out_ready = 1'b1;
        do_job(fill(8'hFD), fill(8'd7), 5'd1, b, lat);
        checks++; if (lat !== 1 || $signed(acc_o) !== -21 || $signed(VV) !== -21) begin failures++; $display("FAIL b2b_job1 got lat=%0d acc=%0d vv=%0d exp 1/-21/-21", lat, $signed(acc_o), $signed(VV)); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle1 got=%b exp=0", busy); end
        do_job(ramp(), fill(8'hFF), 5'd4, b, lat);
        checks++; if (lat !== 1 || $signed(acc_o) !== -6 || $signed(VV) !== -6) begin failures++; $display("FAIL b2b_job2 got lat=%0d acc=%0d vv=%0d exp 1/-6/-6", lat, $signed(acc_o), $signed(VV)); end
        @(posedge clk); #1;
        do_job(ramp(), ramp(), 5'd16, b, lat);
        checks++; if (lat !== 4 || $signed(acc_o) !== 1240) begin failures++; $display("FAIL b2b_job3 got lat=%0d acc=%0d exp 4/1240", lat, $signed(acc_o)); end
        checks++; if ($signed(VV) !== 127 || ovf !== 1'b1 || vv_t !== 8'd0 || ovf_t !== 1'b0) begin failures++; $display("FAIL b2b_job3_scale got vv=%0d/%b trunc=%0d/%b exp 127/1 0/0", $signed(VV), ovf, $signed(vv_t), ovf_t); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_final_idle got busy=%b valid=%b exp 0/0", busy, out_valid); end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_mask();
        test_saturate();
        test_backpressure();
        test_rst_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
